// File: rtl/dc_derr_ctrl_pkg.sv
// Shared definitions for the chroma DC error-diffusion sequencer.
//   - one-hot FSM state encoding
//   - byte offsets inside the 48-bit unit error word and the 32-bit top/left words
//   - helpers computing the stored top/left byte pairs for one chroma channel
package dc_derr_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LAUNCH = 5'b00010,
    ST_RUN    = 5'b00100,
    ST_STORE  = 5'b01000,
    ST_FIN    = 5'b10000
  } state_e;

  // Byte offsets in cdc_derr: {v3,v2,v1,u3,u2,u1}
  localparam int U_E1 = 0;
  localparam int U_E2 = 8;
  localparam int U_E3 = 16;
  localparam int V_E1 = 24;
  localparam int V_E2 = 32;
  localparam int V_E3 = 40;

  // Byte offsets in the top/left words: {v1,v0,u1,u0}
  localparam int U0 = 0;
  localparam int U1 = 8;
  localparam int V0 = 16;
  localparam int V1 = 24;

  // (3*e3) >>> 2 in a 10-bit signed intermediate (3*-128 = -384 still fits),
  // truncated back to 8 bits.
  function automatic logic [7:0] left1_of(input logic [7:0] e3);
    logic signed [9:0] prod;
    prod = $signed({{2{e3[7]}}, e3}) * 10'sd3;
    return 8'(prod >>> 2);
  endfunction

  // {top1, top0} for one channel; top1 wraps in 8 bits.
  function automatic logic [15:0] chan_top(input logic [7:0] e2, input logic [7:0] e3);
    return {e3 - left1_of(e3), e2};
  endfunction

  // {left1, left0} for one channel.
  function automatic logic [15:0] chan_left(input logic [7:0] e1, input logic [7:0] e3);
    return {left1_of(e3), e1};
  endfunction

endpackage

// File: rtl/dc_derr_line_ram.sv
// Top-error line buffer: 1R1W RAM of DEPTH x 32 with registered read.
//   clk, rst_n          clock / async active-low reset (read register only)
//   wr_en/wr_addr/wr_data  write port; out-of-range addresses are dropped
//   rd_en/rd_addr       read request; data appears on rd_data after the edge
//   rd_data             last read value, held until the next read; 0 when the
//                       read address is out of range
// A same-address read and write in one cycle returns the old contents.
module dc_derr_line_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = 32'(wr_addr) < DEPTH;
  assign rd_ok = 32'(rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= rd_ok ? mem[rd_addr] : '0;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/dc_derr_ctrl.sv
// Sequencer and error store for the chroma DC error-diffusion datapath.
//   mb_start/mb_x/mb_y   job request from the MB scheduler (taken when idle)
//   busy/mb_done         job in flight / one-cycle completion pulse
//   overrun/ovr_clr      sticky "request while busy" flag and its clear
//   cdc_start/cdc_x/cdc_y  launch pulse and job coordinates to the unit
//   cdc_top_en/addr/derr   unit's top-error line-buffer read port
//   cdc_left_derr        left-error register
//   cdc_derr/cdc_done    unit result and completion pulse
module dc_derr_ctrl
  import dc_derr_ctrl_pkg::*;
#(
  parameter int MAX_MB_W = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mb_start,
  input  logic [9:0]  mb_x,
  input  logic [9:0]  mb_y,
  output logic        busy,
  output logic        mb_done,
  output logic        overrun,
  input  logic        ovr_clr,
  output logic        cdc_start,
  output logic [9:0]  cdc_x,
  output logic [9:0]  cdc_y,
  input  logic        cdc_top_en,
  input  logic [9:0]  cdc_top_addr,
  output logic [31:0] cdc_top_derr,
  output logic [31:0] cdc_left_derr,
  input  logic [47:0] cdc_derr,
  input  logic        cdc_done
);

  state_e      state_q;
  logic        busy_q;
  logic        mb_done_q;
  logic        overrun_q;
  logic        cdc_start_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [31:0] left_q;
  logic [47:0] cap_q;

  logic [15:0] u_top, v_top, u_left, v_left;
  logic [31:0] top_d, left_d;

  assign u_top  = chan_top (cap_q[U_E2 +: 8], cap_q[U_E3 +: 8]);
  assign v_top  = chan_top (cap_q[V_E2 +: 8], cap_q[V_E3 +: 8]);
  assign u_left = chan_left(cap_q[U_E1 +: 8], cap_q[U_E3 +: 8]);
  assign v_left = chan_left(cap_q[V_E1 +: 8], cap_q[V_E3 +: 8]);

  always_comb begin
    top_d  = '0;
    left_d = '0;
    top_d[U0 +: 8]  = u_top[7:0];
    top_d[U1 +: 8]  = u_top[15:8];
    top_d[V0 +: 8]  = v_top[7:0];
    top_d[V1 +: 8]  = v_top[15:8];
    left_d[U0 +: 8] = u_left[7:0];
    left_d[U1 +: 8] = u_left[15:8];
    left_d[V0 +: 8] = v_left[7:0];
    left_d[V1 +: 8] = v_left[15:8];
  end

  // Actions of a state land on the edge that leaves it, except cdc_start,
  // which is raised on entry so it is high exactly while in LAUNCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      mb_done_q   <= 1'b0;
      cdc_start_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      left_q      <= '0;
      cap_q       <= '0;
    end else begin
      mb_done_q   <= 1'b0;
      cdc_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (mb_start) begin
            x_q         <= mb_x;
            y_q         <= mb_y;
            busy_q      <= 1'b1;
            cdc_start_q <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // A new row starts with no left neighbour.
          if (x_q == 10'd0) begin
            left_q <= '0;
          end
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (cdc_done) begin
            cap_q   <= cdc_derr;
            state_q <= ST_STORE;
          end
        end
        ST_STORE: begin
          left_q  <= left_d;
          state_q <= ST_FIN;
        end
        ST_FIN: begin
          mb_done_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Set has priority over clear so a simultaneous overrun is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (mb_start && busy_q) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  dc_derr_line_ram #(
    .DEPTH (MAX_MB_W),
    .AW    (10)
  ) u_line_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (state_q == ST_STORE),
    .wr_addr (x_q),
    .wr_data (top_d),
    .rd_en   (cdc_top_en),
    .rd_addr (cdc_top_addr),
    .rd_data (cdc_top_derr)
  );

  assign busy          = busy_q;
  assign mb_done       = mb_done_q;
  assign overrun       = overrun_q;
  assign cdc_start     = cdc_start_q;
  assign cdc_x         = x_q;
  assign cdc_y         = y_q;
  assign cdc_left_derr = left_q;

endmodule
